load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store unit between the datapath (ALU address, rt store data, MemRead/MemWrite/BHW/
//  DataMemExtendSign decode) and a req/ack data-memory bus. Builds byte enables, lane-shifts store data,
//  extracts and extends load data, traps misalignment, and drives Stall to freeze PC/regfile until done.
//  Big-endian: byte offset 0 = bits [31:24].
// PARAMETERS
//  TIMEOUT_CYCLES  255  max ACCESS cycles awaiting BusAck (used only with LSU_TIMEOUT_EN)
//  ERR_DATA        32'hDEADBEEF  ReadData value returned on bus timeout
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Reset      in   1   synchronous, active-high
//  Addr       in   32  effective address (ALU result)
//  WriteData  in   32  store data (rt)
//  MemRead    in   1   load request
//  MemWrite   in   1   store request; priority over MemRead when both high
//  BHW        in   2   0=byte 1=half 2=word 3=illegal
//  ExtendSign in   1   1=sign-extend byte/half loads, 0=zero-extend
//  ReadData   out  32  load result, valid in DONE cycle
//  Stall      out  1   hold PC and regfile write
//  AddrError  out  1   1-cycle pulse on misaligned/illegal access
//  BusError   out  1   1-cycle pulse on timeout (0 without LSU_TIMEOUT_EN)
//  BusReq     out  1   bus request, registered
//  BusWe      out  1   1=write
//  BusAddr    out  32  {Addr[31:2],2'b00}
//  BusBE      out  4   byte enables, bit3 = lane [31:24]
//  BusWData   out  32  lane-replicated store data
//  BusRData   in   32  read data, sampled with BusAck
//  BusAck     in   1   transfer complete; ignored while BusReq=0
// BEHAVIOUR
//  - Reset: state IDLE; ReadData, BusReq, BusWe, BusAddr, BusBE, BusWData, AddrError, BusError = 0.
//    Stall = 0. Reset in ACCESS drops BusReq on the next edge; no access is retried.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: start = MemRead|MemWrite. Aligned start: Stall=1 combinationally; next edge loads bus regs,
//    BusReq=1, -> ACCESS. Misaligned (half Addr[0]=1; word Addr[1:0]!=0; BHW=3): no bus cycle, Stall=0,
//    AddrError=1 for the following cycle, ReadData=0, stay IDLE.
//  - ACCESS: Stall=1. BusReq/BusWe/BusAddr/BusBE/BusWData held stable until BusAck=1. On the BusAck
//    edge: BusReq->0, ReadData<=extracted load (0 for store), -> DONE.
//  - DONE: Stall=0 for exactly one cycle, so the instruction retires with ReadData valid; -> IDLE.
//    A memory op in the following instruction starts normally from IDLE.
//  - Minimum access: 1 Stall cycle in IDLE + 1 in ACCESS (ack same cycle) + DONE = 3 cycles.
//  - Byte: BE = 4'b1000 >> Addr[1:0]; WData = {4{WriteData[7:0]}}.
//    Half: BE = Addr[1] ? 0011 : 1100; WData = {2{WriteData[15:0]}}. Word: BE = 1111; WData = WriteData.
//  - Load: select lane by Addr[1:0] (byte) / Addr[1] (half). Extend to 32 per ExtendSign. Word is unmodified.
//  - Start inputs are sampled only in IDLE; changes during ACCESS/DONE are ignored.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: 8-bit cycle counter cleared on entry to ACCESS. If the counter reaches
//    TIMEOUT_CYCLES without BusAck: BusReq->0, ReadData=ERR_DATA (load) or 0 (store),
//    BusError pulses 1 cycle, -> DONE. A late BusAck after abort is ignored.
//  LSU_TIMEOUT_EN undefined: ACCESS waits indefinitely; BusError tied 0; no counter logic.
// TESTING
//  1 LW Addr=0x100, BusRData=0x11223344, ack 1st ACCESS cycle -> BusBE=1111, ReadData=0x11223344, Stall 2 cycles.
//  2 LB Addr=0x103, ExtendSign=1, BusRData=0x000000F0 -> BusBE=0001, ReadData=0xFFFFFFF0;
//    same with ExtendSign=0 -> 0x000000F0.
//  3 SH Addr=0x202, WriteData=0x0000ABCD, ack after 4 cycles -> BusWe=1, BusBE=0011,
//    BusWData=0xABCDABCD, held stable for all 4 cycles.
//  4 LW Addr=0x101 -> no BusReq, AddrError 1-cycle pulse, Stall=0, ReadData=0.
//  5 Reset asserted mid-ACCESS -> BusReq=0 and state IDLE next edge; a late BusAck causes no ReadData change.
//  6 (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8) LW with no ack -> abort after 8 cycles, ReadData=0xDEADBEEF, BusError pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit sitting between the datapath and a req/ack
// data-memory bus. It builds byte enables, replicates store data across the
// lanes, extracts and extends load data, traps misaligned or illegal
// accesses, and raises Stall so PC and regfile hold until the access is done.
// Byte order is big-endian: byte offset 0 is bits [31:24].
//
// Sequence: IDLE -> ACCESS -> DONE -> IDLE. The shortest access takes three
// cycles: one stalled IDLE cycle, one ACCESS cycle with an immediate ack,
// then one DONE cycle in which Stall is low and ReadData is valid.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without BusAck.
//               ReadData is ERR_DATA for a load (0 for a store) and BusError
//               pulses for one cycle.
//   undefined : ACCESS waits for BusAck indefinitely and BusError is tied 0.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles allowed before abort (LSU_TIMEOUT_EN only)
//   ERR_DATA        ReadData returned for a load that timed out
//
// Ports
//   Clk, Reset      clock; synchronous active-high reset
//   Addr            effective address from the ALU
//   WriteData       store data (rt)
//   MemRead         load request
//   MemWrite        store request; wins over MemRead
//   BHW             access size: 0 byte, 1 half, 2 word, 3 illegal
//   ExtendSign      1 sign-extends byte/half loads, 0 zero-extends
//   ReadData        load result, valid in the DONE cycle
//   Stall           freezes PC and regfile write
//   AddrError       one-cycle pulse after a misaligned or illegal request
//   BusError        one-cycle pulse after a bus timeout
//   BusReq, BusWe   registered bus request and write strobe
//   BusAddr         word-aligned bus address
//   BusBE           byte enables, bit 3 = lane [31:24]
//   BusWData        lane-replicated store data
//   BusRData        bus read data, taken together with BusAck
//   BusAck          transfer complete; ignored outside ACCESS
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  BHW,
    input  logic        ExtendSign,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrError,
    output logic        BusError,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBE,
    output logic [31:0] BusWData,
    input  logic [31:0] BusRData,
    input  logic        BusAck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    // Offset, size and extension are captured at start so the load can be
    // extracted after the datapath inputs have moved on.
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;

`ifdef LSU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
`else
    // Timeout parameters only matter when the timeout feature is built in.
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, ERR_DATA};
`endif

    logic        start;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;

    // Request decode: alignment trap, byte enables and lane replication.
    always_comb begin
        start      = MemRead | MemWrite;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = WriteData;
        case (BHW)
            2'd0: begin
                be_new    = 4'b1000 >> Addr[1:0];
                wdata_new = {4{WriteData[7:0]}};
            end
            2'd1: begin
                misaligned = Addr[0];
                be_new     = Addr[1] ? 4'b0011 : 4'b1100;
                wdata_new  = {2{WriteData[15:0]}};
            end
            2'd2: begin
                misaligned = (Addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Load extraction from the bus data using the offset/size captured at start.
    always_comb begin
        byte_lane = BusRData[31:24];
        case (off_q)
            2'd0: byte_lane = BusRData[31:24];
            2'd1: byte_lane = BusRData[23:16];
            2'd2: byte_lane = BusRData[15:8];
            default: byte_lane = BusRData[7:0];
        endcase
        half_lane = off_q[1] ? BusRData[15:0] : BusRData[31:16];
        case (size_q)
            2'd0:    load_val = {{24{sext_q & byte_lane[7]}}, byte_lane};
            2'd1:    load_val = {{16{sext_q & half_lane[15]}}, half_lane};
            default: load_val = BusRData;
        endcase
    end

    // Stall is combinational so the very cycle a good request appears in IDLE
    // already freezes the pipeline; a trapped request never stalls.
    always_comb begin
        Stall = ((state_q == IDLE) && start && !misaligned) || (state_q == ACCESS);
    end

    // Next-state and next-register computation for the whole unit.
    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        addr_err_d  = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        sext_d      = sext_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        addr_err_d  = 1'b1;
                        read_data_d = 32'd0;
                    end else begin
                        state_d     = ACCESS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {Addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                        off_d       = Addr[1:0];
                        size_d      = BHW;
                        sext_d      = ExtendSign;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (BusAck) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    read_data_d = bus_we_q ? 32'd0 : load_val;
                end
`ifdef LSU_TIMEOUT_EN
                // The counter holds the number of ACCESS cycles already spent,
                // so the abort happens at the end of the TIMEOUT_CYCLES-th one.
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    read_data_d = bus_we_q ? 32'd0 : ERR_DATA;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers; reset aborts any access in flight without retry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            read_data_q <= 32'd0;
            addr_err_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= 8'd0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            addr_err_q  <= addr_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign ReadData  = read_data_q;
    assign AddrError = addr_err_q;
    assign BusReq    = bus_req_q;
    assign BusWe     = bus_we_q;
    assign BusAddr   = bus_addr_q;
    assign BusBE     = bus_be_q;
    assign BusWData  = bus_wdata_q;
`ifdef LSU_TIMEOUT_EN
    assign BusError  = bus_err_q;
`else
    assign BusError  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Inputs change on the falling edge and
// outputs are read on the falling edge (plus #1 for the combinational Stall),
// so every check sits half a period away from the rising edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  BHW;
    logic        ExtendSign;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrError;
    logic        BusError;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBE;
    logic [31:0] BusWData;
    logic [31:0] BusRData;
    logic        BusAck;

    int n_compared;
    int n_mismatched;

    load_store_unit #(
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .BHW       (BHW),
        .ExtendSign(ExtendSign),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AddrError (AddrError),
        .BusError  (BusError),
        .BusReq    (BusReq),
        .BusWe     (BusWe),
        .BusAddr   (BusAddr),
        .BusBE     (BusBE),
        .BusWData  (BusWData),
        .BusRData  (BusRData),
        .BusAck    (BusAck)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        BusAck     = 1'b0;
        BusRData   = 32'd0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        Addr = 32'd0; WriteData = 32'd0; BHW = 2'd2; ExtendSign = 1'b0;
        tick(); tick();
        n_compared++;
        if ({ReadData, BusReq, BusWe, BusAddr, BusBE, BusWData, AddrError, BusError, Stall} !== 104'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: rd=%h req=%b we=%b addr=%h be=%b wd=%h ae=%b be=%b st=%b, required all zero",
                     ReadData, BusReq, BusWe, BusAddr, BusBE, BusWData, AddrError, BusError, Stall);
        end
        Reset = 1'b0;
        tick();
    endtask

    // LW 0x100, ack in the first ACCESS cycle: Stall high for exactly 2 cycles.
    task automatic test_load_word();
        Addr = 32'h100; BHW = 2'd2; MemRead = 1'b1;
        #1;
        n_compared++;
        if (Stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lw_stall_idle: got %b want 1", Stall); end
        tick();
        n_compared++;
        if ({BusReq, BusWe, BusAddr, BusBE, Stall} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL lw_access: req=%b we=%b addr=%h be=%b st=%b want 1 0 00000100 1111 1",
                     BusReq, BusWe, BusAddr, BusBE, Stall);
        end
        BusAck = 1'b1; BusRData = 32'h11223344;
        tick();
        BusAck = 1'b0; BusRData = 32'h0;
        #1;
        n_compared++;
        if ({ReadData, Stall, BusReq} !== {32'h11223344, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL lw_done: rd=%h st=%b req=%b want 11223344 0 0", ReadData, Stall, BusReq);
        end
        MemRead = 1'b0;
        tick();
    endtask

    // SH 0x202, ack on the 4th ACCESS cycle; bus must hold even as inputs move.
    task automatic test_store_half();
        Addr = 32'h202; WriteData = 32'h0000ABCD; BHW = 2'd1; MemWrite = 1'b1;
        tick();
        Addr = 32'h3FC; WriteData = 32'h12345678; BHW = 2'd0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_compared++;
            if ({BusReq, BusWe, BusAddr, BusBE, BusWData, Stall} !==
                {1'b1, 1'b1, 32'h200, 4'b0011, 32'hABCDABCD, 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL sh_hold_cycle%0d: req=%b we=%b addr=%h be=%b wd=%h st=%b want 1 1 00000200 0011 abcdabcd 1",
                         c, BusReq, BusWe, BusAddr, BusBE, BusWData, Stall);
            end
            if (c == 4) BusAck = 1'b1;
            tick();
        end
        BusAck = 1'b0;
        #1;
        n_compared++;
        if ({BusReq, Stall, ReadData} !== {1'b0, 1'b0, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL sh_done: req=%b st=%b rd=%h want 0 0 00000000", BusReq, Stall, ReadData);
        end
        MemWrite = 1'b0;
        tick();
    endtask

    // SB at offset 1: single lane enable and byte replication.
    task automatic test_store_byte();
        Addr = 32'h401; WriteData = 32'hFFFFFF5A; BHW = 2'd0; MemWrite = 1'b1;
        tick();
        n_compared++;
        if ({BusBE, BusWData, BusAddr} !== {4'b0100, 32'h5A5A5A5A, 32'h400}) begin
            n_mismatched++;
            $display("[TB] FAIL sb_lanes: be=%b wd=%h addr=%h want 0100 5a5a5a5a 00000400", BusBE, BusWData, BusAddr);
        end
        BusAck = 1'b1;
        tick();
        BusAck = 1'b0; MemWrite = 1'b0;
        tick();
    endtask

    // LB 0x103 with sign extension on and off, then LH at offset 2 / 0.
    task automatic test_load_subword();
        logic [31:0] want_rd [4];
        logic [31:0] addrs   [4];
        logic [31:0] rdata   [4];
        logic [1:0]  sizes   [4];
        logic [3:0]  bes     [4];
        logic        sexts   [4];
        want_rd = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8765, 32'h00001234};
        addrs   = '{32'h103, 32'h103, 32'h102, 32'h100};
        rdata   = '{32'h000000F0, 32'h000000F0, 32'h12348765, 32'h12348765};
        sizes   = '{2'd0, 2'd0, 2'd1, 2'd1};
        bes     = '{4'b0001, 4'b0001, 4'b0011, 4'b1100};
        sexts   = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            Addr = addrs[i]; BHW = sizes[i]; ExtendSign = sexts[i]; MemRead = 1'b1;
            tick();
            n_compared++;
            if (BusBE !== bes[i]) begin
                n_mismatched++;
                $display("[TB] FAIL subword_be%0d: got %b want %b", i, BusBE, bes[i]);
            end
            BusAck = 1'b1; BusRData = rdata[i];
            ExtendSign = ~sexts[i];
            tick();
            BusAck = 1'b0; BusRData = 32'h0;
            n_compared++;
            if (ReadData !== want_rd[i]) begin
                n_mismatched++;
                $display("[TB] FAIL subword_rd%0d: got %h want %h", i, ReadData, want_rd[i]);
            end
            MemRead = 1'b0;
            tick();
        end
    endtask

    // Misaligned LW 0x101, misaligned LH 0x203 and BHW=3: trap only.
    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs = '{32'h101, 32'h203, 32'h100};
        sizes = '{2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            Addr = addrs[i]; BHW = sizes[i]; MemRead = 1'b1;
            #1;
            n_compared++;
            if (Stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_stall%0d: got %b want 0", i, Stall); end
            tick();
            MemRead = 1'b0;
            #1;
            n_compared++;
            if ({AddrError, BusReq, Stall, ReadData} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
                n_mismatched++;
                $display("[TB] FAIL mis_trap%0d: ae=%b req=%b st=%b rd=%h want 1 0 0 00000000",
                         i, AddrError, BusReq, Stall, ReadData);
            end
            tick();
            n_compared++;
            if ({AddrError, BusReq} !== 2'b00) begin
                n_mismatched++;
                $display("[TB] FAIL mis_pulse%0d: ae=%b req=%b want 0 0", i, AddrError, BusReq);
            end
        end
    endtask

    // Second LW follows straight after DONE; request held high through DONE.
    task automatic test_back_to_back();
        Addr = 32'h300; BHW = 2'd2; MemRead = 1'b1;
        tick();
        BusAck = 1'b1; BusRData = 32'hCAFEF00D;
        tick();
        BusAck = 1'b0;
        Addr = 32'h304;
        tick();
        #1;
        n_compared++;
        if ({ReadData, Stall, BusReq} !== {32'hCAFEF00D, 1'b1, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second_idle: rd=%h st=%b req=%b want cafef00d 1 0", ReadData, Stall, BusReq);
        end
        tick();
        n_compared++;
        if ({BusReq, BusAddr} !== {1'b1, 32'h304}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second_access: req=%b addr=%h want 1 00000304", BusReq, BusAddr);
        end
        BusAck = 1'b1; BusRData = 32'h0BADF00D;
        tick();
        BusAck = 1'b0; MemRead = 1'b0;
        n_compared++;
        if (ReadData !== 32'h0BADF00D) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second_rd: got %h want 0badf00d", ReadData);
        end
        tick();
    endtask

    // Reset while in ACCESS, then a stale ack that must be ignored.
    task automatic test_reset_mid_access();
        Addr = 32'h500; BHW = 2'd2; MemRead = 1'b1;
        tick();
        Reset = 1'b1; MemRead = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        n_compared++;
        if ({BusReq, Stall, ReadData} !== {1'b0, 1'b0, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid: req=%b st=%b rd=%h want 0 0 00000000", BusReq, Stall, ReadData);
        end
        BusAck = 1'b1; BusRData = 32'h55555555;
        tick();
        BusAck = 1'b0;
        tick();
        n_compared++;
        if ({BusReq, ReadData} !== {1'b0, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL rst_late_ack: req=%b rd=%h want 0 00000000", BusReq, ReadData);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    // LW with no ack: 8 ACCESS cycles, then abort with ERR_DATA and BusError.
    task automatic test_timeout();
        Addr = 32'h600; BHW = 2'd2; MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_compared++;
            if ({BusReq, BusError} !== 2'b10) begin
                n_mismatched++;
                $display("[TB] FAIL to_wait%0d: req=%b berr=%b want 1 0", c, BusReq, BusError);
            end
            tick();
        end
        BusAck = 1'b1; BusRData = 32'h77777777;
        n_compared++;
        if ({BusReq, BusError, ReadData} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            n_mismatched++;
            $display("[TB] FAIL to_abort: req=%b berr=%b rd=%h want 0 1 deadbeef", BusReq, BusError, ReadData);
        end
        tick();
        BusAck = 1'b0;
        tick();
        n_compared++;
        if ({BusError, ReadData, BusReq} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL to_after: berr=%b rd=%h req=%b want 0 deadbeef 0", BusError, ReadData, BusReq);
        end
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        @(negedge Clk);
        test_reset();
        test_load_word();
        test_store_half();
        test_store_byte();
        test_load_subword();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        n_compared++;
        if (BusError !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL buserror_tied: got %b want 0", BusError);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
